// File: rtl/uart_prot_pkg.sv
// uart_prot_pkg: shared state encoding and tx_sel mux codes for the UART protocol TX sequencer.
// Contents: state_e (FSM states), SEL_* byte-select codes, sel_of() state-to-mux helper.
package uart_prot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SLAVE,
        S_SELF,
        S_POP,
        S_DATA,
        S_STOP,
        S_END
    } state_e;

    localparam logic [1:0] SEL_SLAVE = 2'b00;
    localparam logic [1:0] SEL_DATA  = 2'b01;
    localparam logic [1:0] SEL_STOP  = 2'b10;
    localparam logic [1:0] SEL_SELF  = 2'b11;

    // Non-send states park the mux on slave_addr.
    function automatic logic [1:0] sel_of(state_e s);
        return s == S_SELF ? SEL_SELF :
               s == S_DATA ? SEL_DATA :
               s == S_STOP ? SEL_STOP : SEL_SLAVE;
    endfunction

endpackage

// File: rtl/uart_prot_tx_sequencer_watchdog.sv
// uart_prot_watchdog: loadable down-counter that flags a PHY handshake which never completes.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr_i        : reload to TIMEOUT-1 (asserted when a phy_start is issued)
//   en_i         : count down while waiting for phy_done
//   expire_o     : counter reached zero while enabled
module uart_prot_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr_i ? W'(TIMEOUT - 1) : (en_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire_o = en_i && cnt_q == '0;

endmodule

// File: rtl/uart_prot_tx_sequencer.sv
// uart_prot_tx_sequencer: builds one TX frame (slave addr, self addr, FIFO payload, stop) per Tx enable.
// Ports:
//   glb_clk, glb_rst         : clock, asynchronous active-high reset
//   cfg_tx_en, tx_fifo_empty : frame request and FIFO status
//   tx_sel, tx_fifo_r_en     : byte-select mux code and one-cycle FIFO pop
//   tx_rst                   : one-cycle pulse clearing Tx enable at frame end
//   phy_start/busy/done      : byte handshake with the physical-layer transmitter
//   frame_active, payload_cnt, tx_timeout : status
module uart_prot_tx_sequencer
    import uart_prot_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic       glb_clk,
    input  logic       glb_rst,
    input  logic       cfg_tx_en,
    input  logic       tx_fifo_empty,
    output logic [1:0] tx_sel,
    output logic       tx_fifo_r_en,
    output logic       tx_rst,
    output logic       phy_start,
    input  logic       phy_busy,
    input  logic       phy_done,
    output logic       frame_active,
    output logic [7:0] payload_cnt,
    output logic       tx_timeout
);

    state_e     state_q, state_d;
    logic       waiting_q, waiting_d;
    logic [1:0] tx_sel_q, tx_sel_d;
    logic       r_en_q, r_en_d;
    logic       tx_rst_q, tx_rst_d;
    logic       start_q, start_d;
    logic       active_q, active_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       timeout_q, timeout_d;
    logic       expire;

    uart_prot_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk_i    (glb_clk),
        .rst_i    (glb_rst),
        .clr_i    (start_d),
        .en_i     (waiting_q),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        waiting_d = waiting_q;
        start_d   = 1'b0;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        cnt_inc   = cnt_q + 8'd1;
        if (state_q == S_IDLE) begin
            if (cfg_tx_en && !tx_fifo_empty) begin
                state_d = S_SLAVE;
                cnt_d   = '0;
            end
        end else if (state_q == S_POP) begin
            state_d = S_DATA;
        end else if (state_q == S_END) begin
            state_d = S_IDLE;
        end else if (!waiting_q) begin
            // Start is decided from the registered state, so it can never coincide with state entry.
            start_d   = !phy_busy;
            waiting_d = !phy_busy;
        end else if (phy_done) begin
            waiting_d = 1'b0;
            if (state_q == S_DATA) cnt_d = cnt_inc;
            state_d = state_q == S_SLAVE ? S_SELF :
                      state_q == S_SELF  ? S_POP  :
                      state_q == S_STOP  ? S_END  :
                      (!tx_fifo_empty && cnt_inc < 8'(MAX_BURST)) ? S_POP : S_STOP;
        end else if (expire) begin
            waiting_d = 1'b0;
            timeout_d = 1'b0 | 1'b1;
            state_d   = S_END;
        end
        // Outputs are registered from the next state so they line up with state entry.
        tx_sel_d = sel_of(state_d);
        r_en_d   = state_d == S_POP;
        tx_rst_d = state_d == S_END;
        active_d = state_d != S_IDLE;
    end

    always_ff @(posedge glb_clk or posedge glb_rst) begin
        if (glb_rst) begin
            state_q   <= S_IDLE;
            waiting_q <= 1'b0;
            tx_sel_q  <= SEL_SLAVE;
            r_en_q    <= 1'b0;
            tx_rst_q  <= 1'b0;
            start_q   <= 1'b0;
            active_q  <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waiting_q <= waiting_d;
            tx_sel_q  <= tx_sel_d;
            r_en_q    <= r_en_d;
            tx_rst_q  <= tx_rst_d;
            start_q   <= start_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign tx_sel       = tx_sel_q;
    assign tx_fifo_r_en = r_en_q;
    assign tx_rst       = tx_rst_q;
    assign phy_start    = start_q;
    assign frame_active = active_q;
    assign payload_cnt  = cnt_q;
    assign tx_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_prot_tx_sequencer.sv
// tb_uart_prot_tx_sequencer: scoreboard bench with FIFO, config-block and PHY models around the sequencer.
module tb_uart_prot_tx_sequencer;

    logic       glb_clk = 1'b0;
    logic       glb_rst = 1'b1;
    logic       cfg_tx_en = 1'b0;
    logic       tx_fifo_empty = 1'b1;
    logic       phy_busy = 1'b0;
    logic       phy_done = 1'b0;
    logic [1:0] tx_sel;
    logic       tx_fifo_r_en, tx_rst, phy_start, frame_active, tx_timeout;
    logic [7:0] payload_cnt;

    int checks = 0;
    int errors = 0;
    int fifo_cnt = 0;
    int pops = 0, rsts = 0, tos = 0, starts = 0;
    int done_budget = 1000;
    int busy_cnt = 0;
    int cyc = 0, start_cyc = 0, to_cyc = 0;
    int first, found, rem, acc;
    logic [1:0] exp_sel[$];

    always #5 glb_clk = ~glb_clk;

    uart_prot_tx_sequencer #(.MAX_BURST(4), .TIMEOUT(16)) dut (
        .glb_clk       (glb_clk),
        .glb_rst       (glb_rst),
        .cfg_tx_en     (cfg_tx_en),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_sel        (tx_sel),
        .tx_fifo_r_en  (tx_fifo_r_en),
        .tx_rst        (tx_rst),
        .phy_start     (phy_start),
        .phy_busy      (phy_busy),
        .phy_done      (phy_done),
        .frame_active  (frame_active),
        .payload_cnt   (payload_cnt),
        .tx_timeout    (tx_timeout)
    );

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_frame(int n);
        exp_sel.push_back(2'b00);
        exp_sel.push_back(2'b11);
        repeat (n) exp_sel.push_back(2'b01);
        exp_sel.push_back(2'b10);
    endtask

    task automatic clr_counts();
        pops = 0;
        rsts = 0;
        tos = 0;
        starts = 0;
    endtask

    task automatic load(int n);
        fifo_cnt = n;
        tx_fifo_empty = (n == 0);
    endtask

    task automatic step();
        logic r, t, s;
        r = tx_fifo_r_en;
        t = tx_rst;
        s = phy_start;
        @(posedge glb_clk);
        #1;
        cyc++;
        if (r) begin
            pops++;
            if (fifo_cnt == 0) check("pop_empty", 1, 0);
            else fifo_cnt--;
        end
        if (t) cfg_tx_en = 1'b0;
        phy_done = s && (done_budget > 0);
        if (phy_done) done_budget--;
        if (busy_cnt > 0) busy_cnt--;
        phy_busy = (busy_cnt > 0);
        tx_fifo_empty = (fifo_cnt == 0);
        if (phy_start) begin
            starts++;
            start_cyc = cyc;
            if (exp_sel.size() == 0) check("sel_extra", 1, 0);
            else check("tx_sel", int'(tx_sel), int'(exp_sel.pop_front()));
        end
        if (tx_rst) rsts++;
        if (tx_timeout) begin
            tos++;
            to_cyc = cyc;
        end
    endtask

    task automatic wait_frame(int budget);
        for (int i = 0; i < budget && rsts == 0; i++) step();
        check("frame_done", rsts, 1);
        step();
        step();
    endtask

    initial begin
        repeat (3) @(posedge glb_clk);
        #1;
        check("rst_outs", int'({tx_sel, tx_fifo_r_en, tx_rst, phy_start, frame_active, payload_cnt, tx_timeout}), 0);
        glb_rst = 1'b0;
        clr_counts();

        load(3);
        push_frame(3);
        cfg_tx_en = 1'b1;
        step();
        check("start_active", int'(frame_active), 1);
        check("start_no_pulse", int'(phy_start), 0);
        step();
        check("start_pulse", int'(phy_start), 1);
        wait_frame(300);
        check("t1_pops", pops, 3);
        check("t1_cnt", int'(payload_cnt), 3);
        check("t1_rsts", rsts, 1);
        check("t1_idle", int'(frame_active), 0);
        check("t1_queue", exp_sel.size(), 0);
        check("t1_en_cleared", int'(cfg_tx_en), 0);

        clr_counts();
        load(6);
        push_frame(4);
        cfg_tx_en = 1'b1;
        wait_frame(400);
        check("t2_pops", pops, 4);
        check("t2_cnt", int'(payload_cnt), 4);
        check("t2_left", fifo_cnt, 2);
        clr_counts();
        push_frame(2);
        cfg_tx_en = 1'b1;
        wait_frame(400);
        check("t2b_pops", pops, 2);
        check("t2b_cnt", int'(payload_cnt), 2);
        check("t2b_queue", exp_sel.size(), 0);

        clr_counts();
        load(1);
        push_frame(1);
        busy_cnt = 11;
        phy_busy = 1'b1;
        cfg_tx_en = 1'b1;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (phy_start && first < 0) first = i;
        end
        check("busy_defer", first, 12);
        wait_frame(300);
        check("t3_starts", starts, 4);
        check("t3_queue", exp_sel.size(), 0);

        clr_counts();
        load(2);
        exp_sel.push_back(2'b00);
        exp_sel.push_back(2'b11);
        exp_sel.push_back(2'b01);
        exp_sel.push_back(2'b01);
        done_budget = 3;
        cfg_tx_en = 1'b1;
        wait_frame(300);
        check("to_pulses", tos, 1);
        check("to_delay", to_cyc - start_cyc, 16);
        check("to_cnt", int'(payload_cnt), 1);
        check("to_pops", pops, 2);
        check("to_idle", int'(frame_active), 0);
        check("to_queue", exp_sel.size(), 0);
        done_budget = 1000;

        clr_counts();
        load(0);
        cfg_tx_en = 1'b1;
        acc = 0;
        repeat (10) begin
            step();
            acc = acc | int'({tx_sel, tx_fifo_r_en, tx_rst, phy_start, frame_active, tx_timeout});
        end
        check("idle_quiet", acc, 0);
        load(1);
        push_frame(1);
        wait_frame(300);
        check("t5_cnt", int'(payload_cnt), 1);
        check("t5_pops", pops, 1);

        clr_counts();
        load(3);
        push_frame(3);
        cfg_tx_en = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            step();
            found = int'(phy_start && tx_sel == 2'b01);
        end
        check("t6_reach_data", found, 1);
        glb_rst = 1'b1;
        #1;
        check("t6_async_outs", int'({tx_sel, tx_fifo_r_en, tx_rst, phy_start, frame_active, payload_cnt, tx_timeout}), 0);
        repeat (3) step();
        check("t6_no_tx_rst", rsts, 0);
        exp_sel.delete();
        clr_counts();
        rem = fifo_cnt;
        check("t6_remaining", rem, 2);
        push_frame(rem);
        glb_rst = 1'b0;
        wait_frame(300);
        check("t6_cnt", int'(payload_cnt), rem);
        check("t6_pops", pops, rem);
        check("t6_queue", exp_sel.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/uart_prot_tx_sequencer.md
# uart_prot_tx_sequencer

Protocol-layer transmit sequencer for the UART controller. Once software sets Tx enable and the TX FIFO holds data, it builds one frame: slave address, self address, FIFO payload bytes, then the stop frame. It drives the configuration block's byte-select mux and TX FIFO read strobe, handshakes each byte with the physical-layer transmitter, and clears Tx enable when the frame completes.

## Interface
- MAX_BURST, 16: maximum payload bytes per frame, range 1..255.
- TIMEOUT, 4096: glb_clk cycles to wait for phy_done after phy_start before the frame aborts.

Ports:
- glb_clk  in  1  clock, rising edge.
- glb_rst  in  1  asynchronous, active-high reset.
- cfg_tx_en  in  1  Tx enable from the configuration block.
- tx_fifo_empty  in  1  TX FIFO empty flag.
- tx_sel  out  2  byte-select mux code: 00 slave_addr, 01 FIFO data, 10 stop_frame, 11 self_addr.
- tx_fifo_r_en  out  1  one-cycle TX FIFO pop.
- tx_rst  out  1  one-cycle pulse that clears Tx enable.
- phy_start  out  1  one-cycle start pulse; the PHY latches the selected byte on this cycle.
- phy_busy  in  1  PHY transmitter busy.
- phy_done  in  1  one-cycle pulse when the PHY finishes a byte.
- frame_active  out  1  high in any state other than IDLE.
- payload_cnt  out  8  payload bytes sent in the current or last frame.
- tx_timeout  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, SLAVE, SELF, POP, DATA, STOP, END.
- Each send state (SLAVE, SELF, DATA, STOP) has an internal `waiting` flag, cleared on entry.
  - While `waiting`=0 and phy_busy=0: pulse phy_start and set `waiting`.
  - While `waiting`=1: phy_done advances the state.
- IDLE -> SLAVE when cfg_tx_en=1 and tx_fifo_empty=0. On this transition payload_cnt clears to 0.
- SLAVE (tx_sel=00), on done -> SELF.
- SELF (tx_sel=11), on done -> POP.
- POP: pulse tx_fifo_r_en for one cycle, then -> DATA. The FIFO data is valid from the next cycle.
- DATA (tx_sel=01), on done: payload_cnt += 1.
  - -> POP if tx_fifo_empty=0 and the new payload_cnt < MAX_BURST.
  - Otherwise -> STOP.
- STOP (tx_sel=10), on done -> END.
- END: pulse tx_rst for one cycle, then -> IDLE. Software must write Tx enable again to start the next frame.
- Watchdog: a counter runs while `waiting`=1 and clears on phy_start.
  - When it reaches TIMEOUT-1 without phy_done: pulse tx_timeout and go to END, which still issues tx_rst.
  - payload_cnt holds its value at the abort.
- phy_done while `waiting`=0, or in IDLE/POP/END: ignored.
- cfg_tx_en falling mid-frame: ignored; the frame runs to completion.
- tx_fifo_empty rising mid-frame: the payload ends after the current byte. A POP is never issued with the FIFO empty.
- payload_cnt saturates at MAX_BURST, which is at most 255, so it cannot wrap.
- Reset:
  - Asynchronous, to IDLE with `waiting`=0 and the watchdog cleared.
  - Every output resets to 0: tx_sel=00, tx_fifo_r_en, tx_rst, phy_start, frame_active, payload_cnt, tx_timeout.
  - A reset mid-frame abandons the frame. No tx_rst pulse is emitted.

## Timing
- All outputs are registered. tx_sel changes only on state entry and holds for the whole state.
- Frame start: cfg_tx_en & !tx_fifo_empty sampled at edge N -> SLAVE and frame_active at N+1. The earliest phy_start is at N+2.
- phy_start is never issued in the same cycle as a state entry. tx_sel is therefore stable at least one cycle before phy_start.
- POP timing: tx_fifo_r_en high for exactly one cycle; DATA is entered the following cycle. The earliest phy_start in DATA is two cycles after tx_fifo_r_en.
- Done to next state: one cycle after the edge that samples phy_done.
- Frame overhead with an ideal PHY (phy_done one cycle after phy_start): the frame is deterministic. Exact counts are checked in the test plan.
- END lasts one cycle. IDLE cannot re-trigger before cfg_tx_en has fallen, which happens one cycle after tx_rst.

## Structure
- Shared package `uart_prot_pkg` holds:
  - the state enum;
  - the tx_sel codes SEL_SLAVE=2'b00, SEL_DATA=2'b01, SEL_STOP=2'b10, SEL_SELF=2'b11.
- Optional sub-module `uart_prot_watchdog`: a loadable down-counter with clear, enable and expire outputs.
- Everything else is one FSM module.

## Test plan
- Ideal PHY, 3 bytes in the FIFO, cfg_tx_en=1 -> tx_sel sequence 00,11,01,01,01,10; exactly 3 tx_fifo_r_en pulses; payload_cnt=3; one tx_rst; back to IDLE.
- MAX_BURST=4 with 6 bytes queued -> 4 payload bytes then STOP, payload_cnt=4. The FIFO still holds 2 bytes. After re-enable, the second frame sends 2 payload bytes.
- phy_busy held high for 10 cycles on entry to SLAVE -> phy_start deferred until the first cycle with phy_busy=0, then exactly one pulse.
- TIMEOUT=16, phy_done never arrives in DATA -> tx_timeout pulses 16 cycles after phy_start, then tx_rst, then IDLE. payload_cnt holds its pre-abort count.
- cfg_tx_en=1 with the FIFO empty -> stays in IDLE with no outputs toggling. Then write 1 byte -> frame starts and payload_cnt=1.
- glb_rst asserted mid-DATA -> all outputs 0 in the same cycle; no tx_rst pulse. After release, a fresh frame starts normally.
